// File: rtl/nibble_bus_pkg.sv
// Shared types and constants for the nibble bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_bus_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DATA = 2'd3
    } state_t;

    // Bit positions inside bus_ctl.
    localparam int CTL_STB = 0;
    localparam int CTL_WE  = 1;
    localparam int CTL_A0  = 2;
    localparam int CTL_A1  = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select with owner lock.
// Latency: combinational, result valid in the same cycle as i_decide.
// Backpressure: none; o_valid is low when nothing may be granted.
//
// Ports: i_req/i_lock per requester, i_owner (current bus owner),
//        i_last_owner (owner of the most recently finished transfer),
//        i_decide (arbitration point) -> o_valid, o_winner.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic       i_owner,
    input  logic       i_last_owner,
    input  logic       i_decide,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = 1'b0;
        o_winner = i_owner;
        if (i_decide) begin
            if (i_lock[i_owner] && i_req[i_owner]) begin
                // Locked owner keeps the bus regardless of the other request.
                o_valid  = 1'b1;
                o_winner = i_owner;
            end else if (i_req == 2'b11) begin
                o_valid  = 1'b1;
                o_winner = ~i_last_owner;
            end else if (i_req[0]) begin
                o_valid  = 1'b1;
                o_winner = 1'b0;
            end else if (i_req[1]) begin
                o_valid  = 1'b1;
                o_winner = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Shares the external nibble memory bus between the CPU (m0) and the loader (m1).
// Latency: gnt one cycle after the accepting edge; a transfer lasts 2+WAIT_CYCLES cycles, rvalid the cycle after DATA.
// Backpressure: a requester holds req/addr/we/wdata until its gnt pulse; no queueing beyond the active transfer.
//
// Ports: clk, rst_n; per requester mX_req/lock/we/addr/wdata in, mX_gnt/rvalid/rdata out;
//        bus_addr/bus_ctl/bus_dout/bus_doe out, bus_din in.
module nibble_bus_arbiter
    import nibble_bus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [3:0]        bus_ctl,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_doe,
    input  logic [DATA_W-1:0] bus_din
);

    localparam logic [2:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_wait_cnt;
    logic [2:0]        w_wait_cnt_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_decide;
    logic              w_arb_last;
    logic              w_valid;
    logic              w_winner;
    logic              w_busy;
    logic [3:0]        w_ctl;

    assign w_decide   = (r_state == IDLE) || (r_state == DATA);
    // At the DATA edge last_owner has not yet been updated, so the owner
    // finishing now is what the round-robin must rotate away from.
    assign w_arb_last = (r_state == DATA) ? r_owner : r_last_owner;

    rr_arb2 u_arb (
        .i_req        ({m1_req, m0_req}),
        .i_lock       ({m1_lock, m0_lock}),
        .i_owner      (r_owner),
        .i_last_owner (w_arb_last),
        .i_decide     (w_decide),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_valid) w_state_nxt = ADDR;
            end
            ADDR: begin
                if (WAIT_CYCLES == 0) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WAIT_M1;
                end
            end
            WAIT: begin
                if (r_wait_cnt == 3'd0) w_state_nxt = DATA;
                else                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
            end
            DATA: begin
                w_state_nxt = w_valid ? ADDR : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wait_cnt   <= 3'd0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_gnt        <= 2'b00;
            r_rvalid     <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            if (r_state == DATA) begin
                r_last_owner <= r_owner;
                if (!r_we) begin
                    if (r_owner) begin
                        r_rdata1 <= bus_din;
                        r_rvalid <= 2'b10;
                    end else begin
                        r_rdata0 <= bus_din;
                        r_rvalid <= 2'b01;
                    end
                end
            end
            if (w_valid) begin
                r_owner <= w_winner;
                r_addr  <= w_winner ? m1_addr  : m0_addr;
                r_we    <= w_winner ? m1_we    : m0_we;
                r_wdata <= w_winner ? m1_wdata : m0_wdata;
                r_gnt   <= w_winner ? 2'b10    : 2'b01;
            end
        end
    end

    assign w_busy = (r_state != IDLE);

    always_comb begin
        w_ctl = 4'b0000;
        if (w_busy) begin
            w_ctl[CTL_STB] = 1'b1;
            w_ctl[CTL_WE]  = r_we;
            w_ctl[CTL_A0]  = r_addr[0];
            w_ctl[CTL_A1]  = r_addr[1];
        end
    end

    assign bus_ctl   = w_ctl;
    assign bus_addr  = w_busy ? r_addr[ADDR_W-1:2] : '0;
    assign bus_doe   = w_busy & r_we;
    assign bus_dout  = (w_busy && r_we) ? r_wdata : '0;
    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
module tb_nibble_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       m0_req = 0, m0_lock = 0, m0_we = 0;
    logic [9:0] m0_addr = '0;
    logic [3:0] m0_wdata = '0;
    logic       m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [9:0] m1_addr = '0;
    logic [3:0] m1_wdata = '0;
    logic [3:0] bus_din = '0;

    // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2.
    logic       m0_gnt_o [2];
    logic       m1_gnt_o [2];
    logic       m0_rv_o  [2];
    logic       m1_rv_o  [2];
    logic [3:0] m0_rd_o  [2];
    logic [3:0] m1_rd_o  [2];
    logic [7:0] baddr_o  [2];
    logic [3:0] ctl_o    [2];
    logic [3:0] dout_o   [2];
    logic       doe_o    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nibble_bus_arbiter #(.ADDR_W(10), .DATA_W(4), .WAIT_CYCLES(2 * g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .m0_req    (m0_req),
            .m0_lock   (m0_lock),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_gnt    (m0_gnt_o[g]),
            .m0_rvalid (m0_rv_o[g]),
            .m0_rdata  (m0_rd_o[g]),
            .m1_req    (m1_req),
            .m1_lock   (m1_lock),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_gnt    (m1_gnt_o[g]),
            .m1_rvalid (m1_rv_o[g]),
            .m1_rdata  (m1_rd_o[g]),
            .bus_addr  (baddr_o[g]),
            .bus_ctl   (ctl_o[g]),
            .bus_dout  (dout_o[g]),
            .bus_doe   (doe_o[g]),
            .bus_din   (bus_din)
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] gnt_of(input int k);
        return {m1_gnt_o[k], m0_gnt_o[k]};
    endfunction

    function automatic logic [1:0] rv_of(input int k);
        return {m1_rv_o[k], m0_rv_o[k]};
    endfunction

    // ---------------- transaction-level reference model ----------------
    // Each transfer is a run of 2+WAIT cycles; m_pos is the cycle index
    // within that run, the run's first cycle carries gnt.
    bit         m_in_tx [2] = '{0, 0};
    int         m_pos   [2] = '{0, 0};
    int         m_own   [2] = '{0, 0};
    int         m_last  [2] = '{1, 1};
    bit         m_we    [2] = '{0, 0};
    logic [9:0] m_addr  [2];
    logic [3:0] m_wd    [2];
    logic [1:0] m_rv    [2];
    logic [3:0] m_rd    [2][2];

    task automatic model_step(input int k);
        int len;
        int w;
        bit rq [2];
        bit lk [2];
        len   = 2 + 2 * k;
        w     = -1;
        rq[0] = m0_req;  rq[1] = m1_req;
        lk[0] = m0_lock; lk[1] = m1_lock;
        m_rv[k] = 2'b00;
        if (m_in_tx[k] && m_pos[k] < len - 1) begin
            m_pos[k]++;
            return;
        end
        if (m_in_tx[k]) begin
            if (!m_we[k]) begin
                m_rd[k][m_own[k]] = bus_din;
                m_rv[k][m_own[k]] = 1'b1;
            end
            m_last[k] = m_own[k];
        end
        if (lk[m_own[k]] && rq[m_own[k]]) w = m_own[k];
        else if (rq[0] && rq[1])          w = 1 - m_last[k];
        else if (rq[0])                   w = 0;
        else if (rq[1])                   w = 1;
        m_in_tx[k] = (w >= 0);
        m_pos[k]   = 0;
        if (w >= 0) begin
            m_own[k]  = w;
            m_we[k]   = (w == 1) ? m1_we    : m0_we;
            m_addr[k] = (w == 1) ? m1_addr  : m0_addr;
            m_wd[k]   = (w == 1) ? m1_wdata : m0_wdata;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_in_tx[k] = 0; m_pos[k] = 0; m_own[k] = 0; m_last[k] = 1;
                m_rv[k] = 2'b00; m_rd[k][0] = 4'h0; m_rd[k][1] = 4'h0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic compare(input int k);
        logic [1:0] eg;
        logic [7:0] ea;
        logic [3:0] ec, ed;
        logic       eo;
        eg = 2'b00; ea = 8'h00; ec = 4'h0; ed = 4'h0; eo = 1'b0;
        if (rst_n && m_in_tx[k]) begin
            if (m_pos[k] == 0) eg[m_own[k]] = 1'b1;
            ea = m_addr[k][9:2];
            ec = {m_addr[k][1:0], m_we[k], 1'b1};
            eo = m_we[k];
            ed = m_we[k] ? m_wd[k] : 4'h0;
        end
        chk("gnt",      k, 32'(gnt_of(k)), 32'(eg));
        chk("rvalid",   k, 32'(rv_of(k)),  32'(rst_n ? m_rv[k] : 2'b00));
        chk("m0_rdata", k, 32'(m0_rd_o[k]), 32'(rst_n ? m_rd[k][0] : 4'h0));
        chk("m1_rdata", k, 32'(m1_rd_o[k]), 32'(rst_n ? m_rd[k][1] : 4'h0));
        chk("bus_addr", k, 32'(baddr_o[k]), 32'(ea));
        chk("bus_ctl",  k, 32'(ctl_o[k]),   32'(ec));
        chk("bus_dout", k, 32'(dout_o[k]),  32'(ed));
        chk("bus_doe",  k, 32'(doe_o[k]),   32'(eo));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) compare(k);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int ns, nbad, nrv, n0, n1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_bus_ctl", 0, 32'(ctl_o[0]), 32'h0);
        chk("rst_gnt",     1, 32'(gnt_of(1)), 32'h0);
        tick();
        rst_n = 1'b1;

        // 1: single m0 read, no wait states.
        m0_req = 1; m0_we = 0; m0_addr = 10'h155; bus_din = 4'hA;
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("t1_gnt",      0, 32'(gnt_of(0)),  32'h1);
        chk("t1_bus_addr", 0, 32'(baddr_o[0]), 32'h55);
        chk("t1_bus_ctl",  0, 32'(ctl_o[0]),   32'b0101);
        tick();
        @(negedge clk);
        chk("t1_data_ctl", 0, 32'(ctl_o[0]),   32'b0101);
        chk("t1_data_gnt", 0, 32'(gnt_of(0)),  32'h0);
        tick();
        @(negedge clk);
        chk("t1_rvalid",   0, 32'(rv_of(0)),   32'h1);
        chk("t1_rdata",    0, 32'(m0_rd_o[0]), 32'hA);
        chk("t1_idle",     0, 32'(ctl_o[0]),   32'h0);
        repeat (4) tick();

        // 2: m1 write with two wait states.
        reset_dut();
        m1_req = 1; m1_we = 1; m1_addr = 10'h3FF; m1_wdata = 4'h6;
        tick();
        m1_req = 0;
        ns = 0; nbad = 0; nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ctl_o[1][0]) begin
                ns++;
                if (ctl_o[1] !== 4'hF || doe_o[1] !== 1'b1 || dout_o[1] !== 4'h6) nbad++;
            end
            if (m1_rv_o[1]) nrv++;
            tick();
        end
        chk("t2_strobe_cycles", 1, 32'(ns),   32'd4);
        chk("t2_bad_phase",     1, 32'(nbad), 32'd0);
        chk("t2_rvalid",        1, 32'(nrv),  32'd0);
        @(negedge clk);
        chk("t2_idle", 1, 32'(ctl_o[1]), 32'h0);
        tick();
        m1_we = 0;

        // 3: simultaneous reads from reset.
        reset_dut();
        m0_req = 1; m0_addr = 10'h012; m1_req = 1; m1_addr = 10'h2A7;
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("t3_first_gnt", 0, 32'(gnt_of(0)), 32'h1);
        tick();
        tick();
        m1_req = 0;
        @(negedge clk);
        chk("t3_m1_gnt",   0, 32'(gnt_of(0)),  32'h2);
        chk("t3_rv_olap",  0, 32'(rv_of(0)),   32'h1);
        chk("t3_m1_baddr", 0, 32'(baddr_o[0]), 32'hA9);
        repeat (6) tick();

        // 4: m0 locked for three reads while m1 keeps requesting.
        reset_dut();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        tick();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_gnt_o[0]) n0++;
            if (m1_gnt_o[0]) n1++;
            if (n0 == 3 && m0_req) begin m0_req = 0; m0_lock = 0; end
            tick();
        end
        @(negedge clk);
        chk("t4_m0_gnts",  0, 32'(n0), 32'd3);
        chk("t4_m1_early", 0, 32'(n1), 32'd0);
        chk("t4_m1_gnt",   0, 32'(gnt_of(0)), 32'h2);
        tick();
        m1_req = 0;
        repeat (8) tick();

        // 5: continuous contention, no locks: strict alternation, no bubbles.
        reset_dut();
        m0_req = 1; m1_req = 1; m1_we = 1; m1_wdata = 4'h9;
        tick();
        ns = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ctl_o[0][0]) ns++;
            if (i % 4 == 0) chk("t5_gnt_m0", 0, 32'(gnt_of(0)), 32'h1);
            if (i % 4 == 2) chk("t5_gnt_m1", 0, 32'(gnt_of(0)), 32'h2);
            tick();
        end
        chk("t5_busy_cycles", 0, 32'(ns), 32'd16);
        m0_req = 0; m1_req = 0; m1_we = 0;
        repeat (8) tick();

        // 6: reset during the WAIT of an m0 read.
        reset_dut();
        m0_req = 1; m0_we = 0; m0_addr = 10'h3FD;
        tick();
        m0_req = 0;
        tick();
        chk("t6_wait_ctl", 1, 32'(ctl_o[1]), 32'b0101);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl",   1, 32'(ctl_o[1]),   32'h0);
        chk("t6_rst_baddr", 1, 32'(baddr_o[1]), 32'h0);
        chk("t6_rst_doe",   1, 32'(doe_o[1]),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_rv_o[1] || m0_gnt_o[1] || ctl_o[1] != 4'h0) nrv++;
            tick();
        end
        chk("t6_after_rst", 1, 32'(nrv), 32'd0);

        // Randomized traffic, occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_lock  = ($urandom_range(0, 3) == 0);
            m1_lock  = 1'($urandom_range(0, 1));
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_addr  = 10'($urandom);
            m1_addr  = 10'($urandom);
            m0_wdata = 4'($urandom);
            m1_wdata = 4'($urandom);
            bus_din  = 4'($urandom);
            rst_n    = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        m0_req = 0; m1_req = 0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_bus_arbiter.md
Name: nibble_bus_arbiter

Overview:
- Shares the single external nibble-wide memory bus between two requesters: m0 is the CPU core (fetch, load and store) and m1 is a debug/program loader.
- Sequences each transaction as an address phase, optional wait states and a data phase.
- Performs round-robin arbitration, with a lock so the CPU can hold the bus across multi-nibble sequences.
- Sits between the core and the top-level uo_out/uio pins.

Parameters:
ADDR_W, 10, requester address width; the bus carries addr[ADDR_W-1:2] on bus_addr and addr[1:0] on bus_ctl.
DATA_W, 4, data nibble width.
WAIT_CYCLES, 0, wait states inserted between the ADDR and DATA phases (0..7).

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
m0_req  in  1  m0 transaction request; hold with addr/we/wdata stable until m0_gnt
m0_lock  in  1  m0 keeps the bus after its current transaction if m0_req is still high
m0_we  in  1  1=write, 0=read
m0_addr  in  ADDR_W  nibble address
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  one-cycle pulse: request accepted, inputs latched
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
m0_rdata  out  DATA_W  read data (holds until the next read completes)
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for m1
bus_addr  out  8  address high bits
bus_ctl  out  4  [3:2]=addr[1:0], [1]=we, [0]=strobe
bus_dout  out  DATA_W  write data to memory
bus_doe  out  1  data pin output enable
bus_din  in  DATA_W  read data from memory

Behaviour:
- Reset (asynchronous, immediate) values:
  - state=IDLE, owner=0, last_owner=1 (so m0 wins the first tie).
  - All gnt/rvalid=0; rdata=0.
  - bus_addr=0, bus_ctl=0, bus_dout=0, bus_doe=0.
- States:
  - IDLE: bus outputs idle as at reset.
  - ADDR: exactly 1 cycle.
  - WAIT: WAIT_CYCLES cycles, counted by a down-counter.
  - DATA: exactly 1 cycle.
- Arbitration decision point: at a clock edge in IDLE, or at the final (DATA) edge of a transaction.
  - Lock: if the current owner has lock=1 and req=1, the owner wins.
  - Otherwise, if exactly one req is high, that requester wins.
  - If both are high, the requester != last_owner wins.
  - The winner's addr/we/wdata are latched into the transaction registers; owner=winner; next state=ADDR.
- gnt[owner] is a registered pulse asserted during the ADDR cycle. The requester may change its inputs from the cycle after gnt.
- last_owner is updated at DATA exit.
- Back-to-back transactions: DATA goes directly to ADDR with no IDLE bubble. A transaction occupies 2+WAIT_CYCLES cycles.
- Bus outputs during ADDR/WAIT/DATA:
  - bus_addr=addr[9:2]; bus_ctl={addr[1:0], we, 1}.
  - For writes: bus_doe=1 and bus_dout=wdata throughout all three phases.
  - For reads: bus_doe=0 and bus_dout=0.
- Read completion: bus_din is sampled at the DATA-exit edge into rdata[owner]. rvalid[owner] pulses the cycle after DATA. This overlaps the next ADDR if back-to-back.
- Writes produce no rvalid.
- A request withdrawn before grant: no transaction, no gnt.
- req held high after gnt is treated as a new request (not a duplicate).
- m1 starvation: m1 is bounded only by m0_lock. With lock=0 on both, requesters strictly alternate under continuous contention.
- Reset mid-transaction: bus is released immediately; no gnt/rvalid is emitted for the aborted transfer after rst_n deasserts.
- WAIT_CYCLES=0: the WAIT state is never entered.

Decomposition:
- Package nibble_bus_pkg holds:
  - the state enum (IDLE, ADDR, WAIT, DATA);
  - bus_ctl bit index constants (CTL_STB=0, CTL_WE=1, CTL_A0=2, CTL_A1=3).
- Sub-module rr_arb2: combinational 2-way round-robin/lock winner select. Inputs: req[1:0], lock[1:0], owner, last_owner, decide. Outputs: valid, winner.

Test Plan:
1. WAIT_CYCLES=0; m0 read addr 0x155; bus_din=0xA in DATA
   -> ADDR cycle shows bus_addr=0x55, bus_ctl=4'b0101, m0_gnt=1;
   -> next cycle DATA;
   -> the cycle after, m0_rvalid=1 and m0_rdata=0xA.
2. WAIT_CYCLES=2; m1 write addr 0x3FF, wdata 0x6
   -> strobe high for 4 cycles with bus_ctl=4'b1111, bus_doe=1, bus_dout=0x6;
   -> no m1_rvalid; bus idle afterwards.
3. From reset, m0 and m1 request simultaneously (reads)
   -> m0 granted first;
   -> m1's ADDR immediately follows m0's DATA;
   -> m0_rvalid coincides with m1_gnt.
4. m0 locked, 3 back-to-back reads, m1 requesting throughout
   -> m1_gnt only after m0's third transaction, once m0_lock drops.
5. Both requesters' req held high, locks 0, for 8 transactions
   -> grants alternate m0, m1, m0, ...; no idle cycles.
6. Assert rst_n low during the WAIT of an m0 read
   -> all bus outputs 0 within the same cycle;
   -> after release, no m0_rvalid and state=IDLE.
